// File: rtl/udp_filter.sv
// UDP receive filter: inspects the first five 64-bit beats of each Ethernet
// frame (IPv4 EtherType, IHL=5, UDP protocol, destination address) and
// forwards accepted frames to a downstream FIFO.  On rejection the FIFO is
// held in reset until it reports empty, which discards any partial frame
// already written.
//
// state | meaning
// ------+---------------------------------------------------------------
// HDR   | header beats 0-4 of a frame; each beat checked and written
// PASS  | header accepted, forwarding payload until frame_last_i
// DROP  | frame rejected, discarding words until frame_last_i
// FLUSH | FIFO held in reset until fifo_empty_i; all inputs ignored
module udp_filter (
  input  logic        clk_i,
  input  logic        s_rst_i,
  input  logic        en_i,
  input  logic [31:0] ipv4_addr_i,
  input  logic [63:0] frame_i,
  input  logic        frame_last_i,
  output logic        frame_valid_o,
  output logic        fifo_wr_en_o,
  output logic [63:0] fifo_data_o,
  input  logic        fifo_empty_i,
  output logic        fifo_rst_n_o
);

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [2:0] LAST_HDR_BEAT = 3'd4;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] beat;
  logic [2:0] beat_nxt;
  logic       beat_ok;
  logic       runt;
  logic       accept_word;
  logic       wr_nxt;
  logic       valid_nxt;
  logic       rst_n_nxt;

  // Header field check for the beat currently on frame_i; address compared live.
  always_comb begin
    beat_ok = 1'b1;
    case (beat)
      3'd1: beat_ok = (frame_i[39:32] == 8'h08) && (frame_i[47:40] == 8'h00) &&
                      (frame_i[55:48] == 8'h45);
      3'd2: beat_ok = (frame_i[63:56] == 8'h11);
      3'd3: beat_ok = ({frame_i[55:48], frame_i[63:56]} == ipv4_addr_i[31:16]);
      3'd4: beat_ok = ({frame_i[7:0], frame_i[15:8]} == ipv4_addr_i[15:0]);
      default: beat_ok = 1'b1;
    endcase
  end

  // A frame ending before the last header beat is too short to be a valid UDP frame.
  assign runt        = frame_last_i && (beat != LAST_HDR_BEAT);
  assign accept_word = beat_ok && !runt;

  // State register, beat counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state         <= ST_FLUSH;
      beat          <= 3'd0;
      fifo_wr_en_o  <= 1'b0;
      fifo_data_o   <= 64'd0;
      frame_valid_o <= 1'b0;
      fifo_rst_n_o  <= 1'b0;
    end else begin
      state         <= state_nxt;
      beat          <= beat_nxt;
      fifo_wr_en_o  <= wr_nxt;
      frame_valid_o <= valid_nxt;
      fifo_rst_n_o  <= rst_n_nxt;
      if (wr_nxt) begin
        fifo_data_o <= frame_i;
      end
    end
  end

  // Next-state and beat-counter logic.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      ST_HDR: begin
        if (en_i) begin
          if (frame_last_i) begin
            beat_nxt = 3'd0;
          end else if (beat != LAST_HDR_BEAT) begin
            beat_nxt = beat + 3'd1;
          end
          if (accept_word) begin
            if ((beat == LAST_HDR_BEAT) && !frame_last_i) begin
              state_nxt = ST_PASS;
            end
          end else begin
            state_nxt = frame_last_i ? ST_FLUSH : ST_DROP;
          end
        end
      end
      ST_PASS: begin
        if (en_i && frame_last_i) begin
          state_nxt = ST_HDR;
          beat_nxt  = 3'd0;
        end
      end
      ST_DROP: begin
        if (en_i && frame_last_i) begin
          state_nxt = ST_FLUSH;
          beat_nxt  = 3'd0;
        end
      end
      ST_FLUSH: begin
        // Leaving FLUSH depends only on the FIFO; words arriving here are dropped.
        if (fifo_empty_i) begin
          state_nxt = ST_HDR;
        end
      end
      default: begin
        state_nxt = ST_FLUSH;
        beat_nxt  = 3'd0;
      end
    endcase
  end

  // Output decode; writes only happen while staying in HDR/PASS, so the FIFO is never written in reset.
  always_comb begin
    wr_nxt    = 1'b0;
    valid_nxt = 1'b0;
    rst_n_nxt = (state_nxt == ST_HDR) || (state_nxt == ST_PASS);
    if (en_i) begin
      if (state == ST_PASS) begin
        wr_nxt = 1'b1;
      end else if ((state == ST_HDR) && accept_word) begin
        wr_nxt = 1'b1;
      end
    end
    valid_nxt = wr_nxt && frame_last_i;
  end

endmodule

// File: tb/tb_udp_filter.sv
// Randomised scoreboard bench for udp_filter: a frame-level reference model
// predicts each cycle's FIFO activity; a monitor compares DUT outputs.
module tb_udp_filter;

  logic        clk_i = 1'b0;
  logic        s_rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic [31:0] ipv4_addr_i = 32'hC0A8_0001;
  logic [63:0] frame_i = 64'd0;
  logic        frame_last_i = 1'b0;
  logic        frame_valid_o;
  logic        fifo_wr_en_o;
  logic [63:0] fifo_data_o;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_rst_n_o;

  always #5 clk_i = ~clk_i;

  udp_filter dut (
    .clk_i        (clk_i),
    .s_rst_i      (s_rst_i),
    .en_i         (en_i),
    .ipv4_addr_i  (ipv4_addr_i),
    .frame_i      (frame_i),
    .frame_last_i (frame_last_i),
    .frame_valid_o(frame_valid_o),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rst_n_o (fifo_rst_n_o)
  );

  typedef struct {
    bit          wr;
    bit          valid;
    bit          rst_n;
    bit          chk_data;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: where the filter stands within the current frame.
  typedef enum {M_HDR, M_PASS, M_DROP, M_FLUSH} mode_t;
  mode_t m_mode = M_FLUSH;
  int    m_beat = 0;

  logic [31:0] cur_addr = 32'hC0A8_0001;
  bit          cur_empty = 1'b1;

  logic [63:0] fw[0:15];
  int          flen;

  // Byte k of the frame, taken from beat b.
  function automatic logic [7:0] fbyte(logic [63:0] w, int b, int k);
    logic [63:0] s;
    s = w >> (8 * (k - 8 * b));
    return s[7:0];
  endfunction

  function automatic bit hdr_ok(int b, logic [63:0] w, logic [31:0] a);
    case (b)
      1: return fbyte(w, 1, 12) == 8'h08 && fbyte(w, 1, 13) == 8'h00 && fbyte(w, 1, 14) == 8'h45;
      2: return fbyte(w, 2, 23) == 8'h11;
      3: return fbyte(w, 3, 30) == a[31:24] && fbyte(w, 3, 31) == a[23:16];
      4: return fbyte(w, 4, 32) == a[15:8] && fbyte(w, 4, 33) == a[7:0];
      default: return 1'b1;
    endcase
  endfunction

  task automatic setb(int k, logic [7:0] b);
    fw[k / 8][8 * (k % 8) +: 8] = b;
  endtask

  // kind: 0 good, 1 EtherType 0x86DD, 2 bad version byte, 3 TCP, 4 dst .2, 5 bad upper address
  task automatic build(int kind, int len);
    flen = len;
    for (int i = 0; i < 16; i++) fw[i] = {$urandom, $urandom};
    setb(12, 8'h08); setb(13, 8'h00); setb(14, 8'h45);
    setb(23, 8'h11);
    setb(30, cur_addr[31:24]); setb(31, cur_addr[23:16]);
    setb(32, cur_addr[15:8]);  setb(33, cur_addr[7:0]);
    case (kind)
      1: begin setb(12, 8'h86); setb(13, 8'hDD); end
      2: setb(14, 8'h46);
      3: setb(23, 8'h06);
      4: setb(33, cur_addr[7:0] ^ 8'h03);
      5: setb(30, cur_addr[31:24] ^ 8'h80);
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs and push the model's prediction for it.
  task automatic step(bit rst, bit en, logic [63:0] w, bit last);
    exp_t e;
    @(negedge clk_i);
    s_rst_i = rst; en_i = en; frame_i = w; frame_last_i = last;
    fifo_empty_i = cur_empty; ipv4_addr_i = cur_addr;
    e.wr = 0; e.valid = 0; e.chk_data = 0; e.data = w;
    if (rst) begin
      m_mode = M_FLUSH; m_beat = 0; e.chk_data = 1; e.data = 64'd0;
    end else begin
      case (m_mode)
        M_FLUSH: if (cur_empty) m_mode = M_HDR;
        M_HDR: if (en) begin
          if (hdr_ok(m_beat, w, cur_addr) && !(last && m_beat < 4)) begin
            e.wr = 1; e.valid = last;
            if (last) m_beat = 0;
            else if (m_beat == 4) m_mode = M_PASS;
            else m_beat++;
          end else begin
            m_mode = last ? M_FLUSH : M_DROP;
            m_beat = 0;
          end
        end
        M_PASS: if (en) begin
          e.wr = 1; e.valid = last;
          if (last) begin m_mode = M_HDR; m_beat = 0; end
        end
        M_DROP: if (en && last) m_mode = M_FLUSH;
        default: ;
      endcase
    end
    e.rst_n = (m_mode == M_HDR) || (m_mode == M_PASS);
    if (e.wr) e.chk_data = 1;
    exp_q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
  endtask

  // en_mode: 0 continuous, 1 toggling, 2 random gaps. Sends words [from, to).
  task automatic send_range(int en_mode, int from, int to);
    for (int i = from; i < to; i++) begin
      if (en_mode == 2) begin
        for (int g = 0; g < 4 && $urandom_range(0, 3) == 0; g++) idle(1);
      end
      step(0, 1, fw[i], i == flen - 1);
      if (en_mode == 1) idle(1);
    end
  endtask

  task automatic send(int en_mode);
    send_range(en_mode, 0, flen);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: one prediction per driven cycle, compared just after the sampling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fifo_wr_en", 64'(fifo_wr_en_o), 64'(e.wr));
        chk("frame_valid", 64'(frame_valid_o), 64'(e.valid));
        chk("fifo_rst_n", 64'(fifo_rst_n_o), 64'(e.rst_n));
        if (e.chk_data) chk("fifo_data", fifo_data_o, e.data);
        if ((fifo_wr_en_o || frame_valid_o) && !fifo_rst_n_o)
          chk("write_in_reset", 64'(fifo_wr_en_o | frame_valid_o), 64'd0);
      end
    end
  end

  initial begin
    int kind;
    int cut;
    // Reset with FIFO empty: reset FIFO during reset, released one cycle later.
    cur_empty = 1;
    for (int i = 0; i < 3; i++) step(1, 1, {$urandom, $urandom}, 0);
    idle(3);
    // Accepted 8-beat frame, continuous enable.
    build(0, 8); send(0);
    // IPv6 EtherType, then return to HDR.
    build(1, 8); send(0); idle(2);
    // TCP, wrong low address, wrong high address.
    build(3, 8); send(0); idle(2);
    build(4, 8); send(0); idle(2);
    build(5, 6); send(0); idle(2);
    build(2, 4); send(0); idle(2);
    // Back-to-back accepted frames, including one ending on the last header beat.
    build(0, 5); send(0);
    build(0, 9); send(0);
    build(0, 7); send(0);
    // Toggling enable.
    build(0, 8); send(1);
    // Runt, FIFO not empty for a while, following frame dropped until empty.
    build(0, 3); send(0);
    cur_empty = 0; idle(5);
    build(0, 8); send_range(0, 0, 4);
    cur_empty = 1; send_range(0, 4, 8); idle(3);
    // Reset in the middle of an accepted frame.
    build(0, 8); send_range(0, 0, 3);
    step(1, 1, {$urandom, $urandom}, 0);
    cur_empty = 0; send_range(0, 3, 5);
    cur_empty = 1; send_range(0, 5, 8); idle(2);
    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) cur_addr = $urandom;
      if ($urandom_range(0, 3) == 0) cur_empty = 1'($urandom_range(0, 1));
      else cur_empty = 1;
      kind = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 5));
      build(kind, int'($urandom_range(1, 10)));
      if ($urandom_range(0, 19) == 0) begin
        cut = int'($urandom_range(0, flen - 1));
        send_range(2, 0, cut);
        step(1, 1, {$urandom, $urandom}, 0);
        send_range(2, cut, flen);
      end else begin
        send(int'($urandom_range(0, 2)));
      end
      if ($urandom_range(0, 3) == 0) begin
        cur_empty = 1; idle(int'($urandom_range(1, 3)));
      end
    end
    cur_empty = 1; idle(3);
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk_i);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/udp_filter.md
UDP_FILTER -- requirements
Module: udp_filter

Interface
REQ-001 SHALL have a single clock, clk_i; reset s_rst_i is synchronous and active-high.
REQ-002 Ports, in this order:
- clk_i in 1: clock.
- s_rst_i in 1: synchronous active-high reset.
- en_i in 1: input word valid qualifier.
- ipv4_addr_i in 32: local IPv4 address, big-endian value (e.g. 192.168.0.1 = 0xC0A80001).
- frame_i in 64: Ethernet frame word; frame byte 8k+n is on bits [8n+7:8n] of beat k.
- frame_last_i in 1: last word of frame.
- frame_valid_o out 1: accepted-frame-complete pulse.
- fifo_wr_en_o out 1: downstream FIFO write enable.
- fifo_data_o out 64: downstream FIFO write data.
- fifo_empty_i in 1: downstream FIFO empty flag.
- fifo_rst_n_o out 1: downstream FIFO reset, active-low.

Function
REQ-003 A word is consumed only in cycles where en_i=1; with en_i=0, state, beat counter and outputs (except single-cycle pulses, which return to 0) SHALL hold.
REQ-004 States: HDR (beats 0-4 of a frame), PASS (accepted, forwarding), DROP (rejected, discarding), FLUSH (waiting for FIFO clear).
REQ-005 The beat counter SHALL be 3 bits, count consumed words in HDR, saturate at 4, and clear on every frame_last_i.
REQ-006 Header checks (all SHALL pass):
- Beat 1: bytes 12-13 = 0x08,0x00 (EtherType IPv4); byte 14 = 0x45.
- Beat 2: byte 23 = 0x11 (UDP).
- Beat 3: bytes 30-31 = ipv4_addr_i[31:16].
- Beat 4: bytes 32-33 = ipv4_addr_i[15:0].
- Beat 0 has no check.
REQ-007 The check SHALL be combinational on the current frame_i; all outputs SHALL be registered, giving 1-cycle latency from input word to output.
REQ-008 HDR, beat passes: write the word (next cycle fifo_wr_en_o=1, fifo_data_o=frame_i). On beat 4 pass: go to PASS, or stay in HDR if frame_last_i=1.
REQ-009 HDR, beat fails: do not write the word; fifo_rst_n_o=0 from the next cycle. Go to DROP, or FLUSH if frame_last_i=1.
REQ-010 HDR, frame_last_i=1 before beat 4 without a failure (runt frame) SHALL be a reject per REQ-009 (word not written, enter FLUSH).
REQ-011 PASS: every consumed word SHALL be written; on frame_last_i go to HDR.
REQ-012 frame_valid_o SHALL pulse for one cycle, in the same cycle as the FIFO write of the last word of an accepted frame.
REQ-013 DROP: no writes, fifo_rst_n_o=0; on frame_last_i go to FLUSH.
REQ-014 FLUSH: no writes, fifo_rst_n_o=0; inputs ignored; when fifo_empty_i=1 go to HDR with fifo_rst_n_o=1 the next cycle. Minimum FLUSH duration is 1 cycle.
REQ-015 Words arriving during FLUSH SHALL be discarded.
REQ-016 Back-to-back frames SHALL be supported with no idle cycle between them in HDR/PASS.
REQ-017 fifo_wr_en_o and frame_valid_o SHALL never be 1 while fifo_rst_n_o=0.
REQ-018 ipv4_addr_i SHALL be compared live (not latched) at beats 3 and 4.

Reset
REQ-019 While s_rst_i=1, on the next edge: state=FLUSH, counter=0, fifo_wr_en_o=0, fifo_data_o=0, frame_valid_o=0, fifo_rst_n_o=0.
REQ-020 After reset, FLUSH SHALL be left only per REQ-014.
REQ-021 Reset asserted mid-frame SHALL abort the frame; the remainder of that frame, if still arriving, is discarded via FLUSH/HDR rules.

Verification
REQ-022 Reset then fifo_empty_i=1 -> fifo_rst_n_o=0 during reset, 1 one cycle after release; no writes.
REQ-023 ipv4_addr_i=0xC0A80001, 8-beat UDP frame to 192.168.0.1, en_i=1 continuous -> 8 writes, data equal to input delayed 1 cycle; frame_valid_o=1 on the 8th write only.
REQ-024 Same frame with EtherType 0x86DD -> beat 0 written; fifo_rst_n_o=0 from the cycle after beat 1; zero further writes; frame_valid_o stays 0; returns to HDR after frame_last and fifo_empty_i=1.
REQ-025 Protocol 0x06 (TCP), or dst IP 192.168.0.2 -> rejected at beat 2 (or beat 4 respectively); no frame_valid_o.
REQ-026 Accepted frame with en_i toggling 1/0 each cycle -> identical write data sequence; writes only after enabled cycles.
REQ-027 3-beat runt frame -> rejected; then with fifo_empty_i held 0 for 5 cycles -> fifo_rst_n_o stays 0 and a following valid frame is dropped until empty is seen.
